// File: rtl/if_s_if.sv
// ---------------------------------------------------------------------------
// inf_IF_ID : IF/ID pipeline register bundle between fetch and decode.
//   pc   [ADDR_BITS-1:0] : address of the instruction held in IF/ID
//   inst [31:0]          : instruction word (NOP bubble when nothing valid)
// Modports:
//   IF2ID : fetch side, drives pc/inst
//   ID    : decode side, reads pc/inst
// ---------------------------------------------------------------------------
interface inf_IF_ID #(
  parameter int ADDR_BITS = 32
);
  logic [ADDR_BITS-1:0] pc;
  logic [31:0]          inst;

  modport IF2ID (output pc, output inst);
  modport ID    (input  pc, input  inst);
endinterface

// File: rtl/if_s.sv
// ---------------------------------------------------------------------------
// if_s : instruction-fetch stage of the five-stage RV32I core.
// Owns the PC, runs the instruction-memory request handshake and writes the
// IF/ID register. Handles memory wait states, EX redirects (also while a
// fetch is outstanding) and hazard-unit stalls.
// Ports:
//   clk            : clock, rising edge
//   rst            : synchronous active-high reset
//   if2id_o        : IF/ID register (pc, inst), both registered
//   stall_i        : hold IF/ID, do not advance fetch
//   redirect_i     : taken branch/jump from EX, flushes IF/ID
//   redirect_pc_i  : redirect target, bits [1:0] ignored
//   im_req_o       : fetch request valid (registered)
//   im_addr_o      : fetch address (registered, word aligned)
//   im_ack_i       : memory accepts request, data returned same cycle
//   im_rdata_i     : instruction word, valid when im_req_o & im_ack_i
// ---------------------------------------------------------------------------
module if_s #(
  parameter int                   ADDR_BITS = 32,
  parameter logic [ADDR_BITS-1:0] RESET_PC  = {ADDR_BITS{1'b0}},
  parameter logic [31:0]          NOP_INST  = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 rst,
  inf_IF_ID.IF2ID              if2id_o,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [ADDR_BITS-1:0] redirect_pc_i,
  output logic                 im_req_o,
  output logic [ADDR_BITS-1:0] im_addr_o,
  input  logic                 im_ack_i,
  input  logic [31:0]          im_rdata_i
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  localparam logic [ADDR_BITS-1:0] PC_STEP   = ADDR_BITS'(3'd4);
  // Clears the two low bits; reading every bit of the target keeps it aligned.
  localparam logic [ADDR_BITS-1:0] ALIGN_MSK = ~(ADDR_BITS'(2'b11));

  state_t               state_q,    state_d;
  logic                 im_req_q,   im_req_d;
  logic [ADDR_BITS-1:0] req_addr_q, req_addr_d;
  logic [ADDR_BITS-1:0] pend_pc_q,  pend_pc_d;
  logic [ADDR_BITS-1:0] buf_pc_q,   buf_pc_d;
  logic [31:0]          buf_inst_q, buf_inst_d;
  logic [ADDR_BITS-1:0] id_pc_q,    id_pc_d;
  logic [31:0]          id_inst_q,  id_inst_d;

  logic                 ack_s;
  logic [ADDR_BITS-1:0] tgt_s;

  assign ack_s = im_req_q & im_ack_i;
  assign tgt_s = redirect_pc_i & ALIGN_MSK;

  assign im_req_o     = im_req_q;
  assign im_addr_o    = req_addr_q;
  assign if2id_o.pc   = id_pc_q;
  assign if2id_o.inst = id_inst_q;

  // Next-state, next-PC and IF/ID update logic.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    pend_pc_d  = pend_pc_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;

    case (state_q)
      ST_START: begin
        // One idle cycle after reset before the first request.
        state_d = ST_FETCH;
      end

      ST_FETCH: begin
        if (redirect_i && ack_s) begin
          // Fetched word is on the wrong path: bubble, restart at target.
          id_pc_d    = tgt_s;
          id_inst_d  = NOP_INST;
          req_addr_d = tgt_s;
        end else if (redirect_i) begin
          // Request must stay stable until acked, so remember the target.
          id_inst_d = NOP_INST;
          pend_pc_d = tgt_s;
          state_d   = ST_DROP;
        end else if (stall_i && ack_s) begin
          // Decode is frozen: park the word so it is not lost.
          buf_pc_d   = req_addr_q;
          buf_inst_d = im_rdata_i;
          state_d    = ST_HOLD;
        end else if (stall_i) begin
          state_d = ST_FETCH;
        end else if (ack_s) begin
          id_pc_d    = req_addr_q;
          id_inst_d  = im_rdata_i;
          req_addr_d = req_addr_q + PC_STEP;
        end else begin
          // Wait state: bubble tagged with the address still in flight.
          id_pc_d   = req_addr_q;
          id_inst_d = NOP_INST;
        end
      end

      ST_HOLD: begin
        if (redirect_i) begin
          buf_pc_d   = {ADDR_BITS{1'b0}};
          buf_inst_d = 32'h0000_0000;
          id_inst_d  = NOP_INST;
          req_addr_d = tgt_s;
          state_d    = ST_FETCH;
        end else if (stall_i) begin
          state_d = ST_HOLD;
        end else begin
          id_pc_d    = buf_pc_q;
          id_inst_d  = buf_inst_q;
          req_addr_d = buf_pc_q + PC_STEP;
          state_d    = ST_FETCH;
        end
      end

      ST_DROP: begin
        // Stale request still outstanding; nothing useful reaches decode.
        id_inst_d = NOP_INST;
        if (redirect_i) begin
          pend_pc_d = tgt_s;
        end else begin
          pend_pc_d = pend_pc_q;
        end
        if (ack_s) begin
          // A redirect in the ack cycle is newer than the stored one.
          req_addr_d = redirect_i ? tgt_s : pend_pc_q;
          state_d    = ST_FETCH;
        end else begin
          state_d = ST_DROP;
        end
      end

      default: begin
        state_d = ST_START;
      end
    endcase

    im_req_d = (state_d == ST_FETCH) || (state_d == ST_DROP);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_START;
      im_req_q   <= 1'b0;
      req_addr_q <= RESET_PC;
      pend_pc_q  <= {ADDR_BITS{1'b0}};
      buf_pc_q   <= {ADDR_BITS{1'b0}};
      buf_inst_q <= 32'h0000_0000;
      id_pc_q    <= {ADDR_BITS{1'b0}};
      id_inst_q  <= NOP_INST;
    end else begin
      state_q    <= state_d;
      im_req_q   <= im_req_d;
      req_addr_q <= req_addr_d;
      pend_pc_q  <= pend_pc_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
    end
  end

endmodule

// File: tb/tb_if_s.sv
// ---------------------------------------------------------------------------
// tb_if_s : directed table-driven bench for if_s. Memory returns its own
// address as data. Each row is one clock: inputs applied, then the state
// after the rising edge compared against hand-computed values.
// ---------------------------------------------------------------------------
module tb_if_s;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack = 1'b0;
  logic [31:0] im_rdata;

  inf_IF_ID #(.ADDR_BITS(32)) if2id ();

  if_s #(
    .ADDR_BITS(32),
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if2id_o      (if2id),
    .stall_i      (stall),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .im_req_o     (im_req),
    .im_addr_o    (im_addr),
    .im_ack_i     (im_ack),
    .im_rdata_i   (im_rdata)
  );

  // Memory word equals its address.
  assign im_rdata = im_addr;

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        st;
    logic        rd;
    logic [31:0] rpc;
    logic        ack;
    logic        e_req;
    logic [31:0] e_addr;
    logic        c_pc;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
  } vec_t;

  vec_t vq[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic addv(input logic r, input logic st, input logic rd,
                      input logic [31:0] rpc, input logic ack,
                      input logic e_req, input logic [31:0] e_addr,
                      input logic c_pc, input logic [31:0] e_pc,
                      input logic [31:0] e_inst);
    vec_t v;
    v.r = r; v.st = st; v.rd = rd; v.rpc = rpc; v.ack = ack;
    v.e_req = e_req; v.e_addr = e_addr; v.c_pc = c_pc;
    v.e_pc = e_pc; v.e_inst = e_inst;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outs(input int idx, input logic e_req,
                            input logic [31:0] e_addr, input logic c_pc,
                            input logic [31:0] e_pc, input logic [31:0] e_inst);
    chk("im_req", idx, {31'd0, im_req}, {31'd0, e_req});
    chk("im_addr", idx, im_addr, e_addr);
    if (c_pc) chk("id_pc", idx, if2id.pc, e_pc);
    chk("id_inst", idx, if2id.inst, e_inst);
  endtask

  initial begin
    //    r  st rd rpc            ack | req addr          cpc pc            inst
    // reset, then START
    addv(1, 0, 0, 32'h0,         0,   0, 32'h0,          1, 32'h0,         NOP);
    addv(1, 0, 0, 32'h0,         0,   0, 32'h0,          1, 32'h0,         NOP);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h0,          1, 32'h0,         NOP);
    // streaming fetch
    addv(0, 0, 0, 32'h0,         1,   1, 32'h4,          1, 32'h0,         32'h0);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h8,          1, 32'h4,         32'h4);
    // three wait states on 0x8
    addv(0, 0, 0, 32'h0,         0,   1, 32'h8,          1, 32'h8,         NOP);
    addv(0, 0, 0, 32'h0,         0,   1, 32'h8,          1, 32'h8,         NOP);
    addv(0, 0, 0, 32'h0,         0,   1, 32'h8,          1, 32'h8,         NOP);
    addv(0, 0, 0, 32'h0,         1,   1, 32'hC,          1, 32'h8,         32'h8);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h10,         1, 32'hC,         32'hC);
    // stall two cycles starting with ack on 0x10
    addv(0, 1, 0, 32'h0,         1,   0, 32'h10,         1, 32'hC,         32'hC);
    addv(0, 1, 0, 32'h0,         1,   0, 32'h10,         1, 32'hC,         32'hC);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h14,         1, 32'h10,        32'h10);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h18,         1, 32'h14,        32'h14);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h1C,         1, 32'h18,        32'h18);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h20,         1, 32'h1C,        32'h1C);
    // redirect to 0x103 with ack on 0x20
    addv(0, 0, 1, 32'h103,       1,   1, 32'h100,        1, 32'h100,       NOP);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h104,        1, 32'h100,       32'h100);
    addv(0, 0, 1, 32'h40,        1,   1, 32'h40,         1, 32'h40,        NOP);
    // redirect to 0x200 while 0x40 waits two more cycles
    addv(0, 0, 1, 32'h200,       0,   1, 32'h40,         0, 32'h0,         NOP);
    addv(0, 0, 0, 32'h0,         0,   1, 32'h40,         0, 32'h0,         NOP);
    addv(0, 0, 0, 32'h0,         0,   1, 32'h40,         0, 32'h0,         NOP);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h200,        0, 32'h0,         NOP);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h204,        1, 32'h200,       32'h200);
    // stall without ack holds, redirect beats stall
    addv(0, 1, 0, 32'h0,         0,   1, 32'h204,        1, 32'h200,       32'h200);
    addv(0, 1, 1, 32'h300,       1,   1, 32'h300,        1, 32'h300,       NOP);
    // stall with ack, then redirect out of HOLD drops the buffer
    addv(0, 1, 0, 32'h0,         1,   0, 32'h300,        1, 32'h300,       NOP);
    addv(0, 1, 1, 32'h500,       0,   1, 32'h500,        0, 32'h0,         NOP);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h504,        1, 32'h500,       32'h500);
    // DROP: newest redirect wins, stall ignored
    addv(0, 0, 1, 32'h600,       0,   1, 32'h504,        0, 32'h0,         NOP);
    addv(0, 1, 1, 32'h700,       0,   1, 32'h504,        0, 32'h0,         NOP);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h700,        0, 32'h0,         NOP);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h704,        1, 32'h700,       32'h700);
    // DROP: redirect in the ack cycle overrides the stored target
    addv(0, 0, 1, 32'h800,       0,   1, 32'h704,        0, 32'h0,         NOP);
    addv(0, 0, 1, 32'h880,       1,   1, 32'h880,        0, 32'h0,         NOP);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h884,        1, 32'h880,       32'h880);
    // reset in the middle of DROP
    addv(0, 0, 1, 32'h900,       0,   1, 32'h884,        0, 32'h0,         NOP);
    addv(1, 0, 0, 32'h0,         1,   0, 32'h0,          1, 32'h0,         NOP);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h0,          1, 32'h0,         NOP);
    // address wrap
    addv(0, 0, 1, 32'hFFFF_FFFF, 1,   1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC, NOP);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h0,          1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    addv(0, 0, 0, 32'h0,         1,   1, 32'h4,          1, 32'h0,         32'h0);

    foreach (vq[i]) begin
      rst         = vq[i].r;
      stall       = vq[i].st;
      redirect    = vq[i].rd;
      redirect_pc = vq[i].rpc;
      im_ack      = vq[i].ack;
      @(posedge clk);
      #1;
      check_outs(i, vq[i].e_req, vq[i].e_addr, vq[i].c_pc, vq[i].e_pc, vq[i].e_inst);
    end

    // Long stall with ack on 0x4: buffer held, IF/ID frozen, request idle.
    rst = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    stall = 1'b1; im_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check_outs(100 + k, 1'b0, 32'h4, 1'b1, 32'h0, 32'h0);
    end
    // Release: held word appears exactly once, next fetch is 0x8.
    stall = 1'b0;
    @(posedge clk);
    #1;
    check_outs(105, 1'b1, 32'h8, 1'b1, 32'h4, 32'h4);
    @(posedge clk);
    #1;
    check_outs(106, 1'b1, 32'hC, 1'b1, 32'h8, 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
